// File: rtl/traffic_light_safety_monitor.sv
// Lamp-path safety monitor: registers the controller's six lamp requests toward the drivers and polices them.
// Latency: 1 cycle from lamp request to lamp drive; a violation forces fail-safe lamps on the next edge.
// Backpressure: none; it is a pure streaming observer, and fault mode holds until a qualified clear_fault.
module traffic_light_safety_monitor #(
    parameter int YELLOW_MIN = 3,
    parameter int YELLOW_MAX = 250,
    parameter int BLINK_HALF = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       red1,
    input  logic       yellow1,
    input  logic       green1,
    input  logic       red2,
    input  logic       yellow2,
    input  logic       green2,
    input  logic       clear_fault,
    output logic       lamp_r1,
    output logic       lamp_y1,
    output logic       lamp_g1,
    output logic       lamp_r2,
    output logic       lamp_y2,
    output logic       lamp_g2,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int DW = $clog2(YELLOW_MAX + 2);
    localparam int BW = $clog2(BLINK_HALF + 1);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FAULT  = 1'b1;

    // Lamp triples are packed {R, Y, G}.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [2:0] CODE_NONE   = 3'd0;
    localparam logic [2:0] CODE_ONEHOT = 3'd1;
    localparam logic [2:0] CODE_CONFL  = 3'd2;
    localparam logic [2:0] CODE_ORDER  = 3'd3;
    localparam logic [2:0] CODE_SHORTY = 3'd4;
    localparam logic [2:0] CODE_LONGY  = 3'd5;

    localparam logic [DW-1:0] DWELL_SAT  = DW'(YELLOW_MAX + 1);
    localparam logic [DW-1:0] DWELL_MAX  = DW'(YELLOW_MAX);
    localparam logic [DW-1:0] DWELL_MIN  = DW'(YELLOW_MIN);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    // Exactly one of R/Y/G lit is the only legal shape for a direction.
    function automatic logic onehot_bad(input logic [2:0] l);
        return !((l == 3'b100) || (l == 3'b010) || (l == 3'b001));
    endfunction

    // Legal moves are G->Y, Y->R, R->G, which in {R,Y,G} packing is a rotate-left by one.
    function automatic logic order_bad(input logic [2:0] prev, input logic [2:0] cur);
        return (cur != prev) && (cur != {prev[1:0], prev[2]});
    endfunction

    // Next yellow dwell: count while Y is lit, saturate just past the limit, drop to 0 when Y goes dark.
    function automatic logic [DW-1:0] dwell_next(input logic y, input logic [DW-1:0] cnt);
        if (!y) begin
            return '0;
        end
        if (cnt == DWELL_SAT) begin
            return DWELL_SAT;
        end
        return cnt + DW'(1);
    endfunction

    logic [0:0]    state_q,     state_d;
    logic [2:0]    code_q,      code_d;
    logic          armed_q,     armed_d;
    logic [2:0]    prev1_q,     prev1_d;
    logic [2:0]    prev2_q,     prev2_d;
    logic [DW-1:0] dwell1_q,    dwell1_d;
    logic [DW-1:0] dwell2_q,    dwell2_d;
    logic          blink_q,     blink_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [2:0]    lamp1_q,     lamp1_d;
    logic [2:0]    lamp2_q,     lamp2_d;

    logic [2:0] cur1;
    logic [2:0] cur2;
    logic       chk_onehot;
    logic       chk_confl;
    logic       chk_order;
    logic       chk_shorty;
    logic       chk_longy;
    logic [2:0] viol_code;

    assign cur1 = {red1, yellow1, green1};
    assign cur2 = {red2, yellow2, green2};

    // Evaluate all safety checks on the current requests against last cycle's history.
    always_comb begin
        chk_onehot = onehot_bad(cur1) || onehot_bad(cur2);
        chk_confl  = !red1 && !red2;
        // Order history is only trustworthy once a clean cycle has been observed.
        chk_order  = armed_q && (order_bad(prev1_q, cur1) || order_bad(prev2_q, cur2));
        // Leaving yellow: Y dark now but the dwell counter still holds the run just ended.
        chk_shorty = (!yellow1 && (dwell1_q != '0) && (dwell1_q < DWELL_MIN)) ||
                     (!yellow2 && (dwell2_q != '0) && (dwell2_q < DWELL_MIN));
        // This Y cycle would be dwell YELLOW_MAX+1.
        chk_longy  = (yellow1 && (dwell1_q >= DWELL_MAX)) ||
                     (yellow2 && (dwell2_q >= DWELL_MAX));
    end

    // Lowest code wins when several checks fire together.
    always_comb begin
        viol_code = CODE_NONE;
        if (chk_onehot) begin
            viol_code = CODE_ONEHOT;
        end else if (chk_confl) begin
            viol_code = CODE_CONFL;
        end else if (chk_order) begin
            viol_code = CODE_ORDER;
        end else if (chk_shorty) begin
            viol_code = CODE_SHORTY;
        end else if (chk_longy) begin
            viol_code = CODE_LONGY;
        end
    end

    // Next-state for the mode FSM, lamp drive, blink generator and history registers.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        armed_d     = armed_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        lamp1_d     = lamp1_q;
        lamp2_d     = lamp2_q;
        prev1_d     = cur1;
        prev2_d     = cur2;
        dwell1_d    = dwell_next(yellow1, dwell1_q);
        dwell2_d    = dwell_next(yellow2, dwell2_q);

        case (state_q)
            ST_NORMAL: begin
                lamp1_d = cur1;
                lamp2_d = cur2;
                if (viol_code != CODE_NONE) begin
                    // A violation beats a same-cycle clear_fault, which means nothing in NORMAL anyway.
                    state_d     = ST_FAULT;
                    code_d      = viol_code;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                    lamp1_d     = LAMP_RED;
                    lamp2_d     = LAMP_RED;
                end else begin
                    armed_d = 1'b1;
                end
            end
            default: begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_d     = !blink_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
                lamp1_d = {blink_d, 2'b00};
                lamp2_d = {blink_d, 2'b00};
                // Only leave fail-safe when the requests being handed back are well formed.
                if (clear_fault && !chk_onehot && !chk_confl) begin
                    state_d     = ST_NORMAL;
                    code_d      = CODE_NONE;
                    armed_d     = 1'b0;
                    dwell1_d    = '0;
                    dwell2_d    = '0;
                    blink_d     = 1'b0;
                    blink_cnt_d = '0;
                    lamp1_d     = cur1;
                    lamp2_d     = cur2;
                end
            end
        endcase
    end

    // Mode, latched fault code and order-check arming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_NORMAL;
            code_q  <= CODE_NONE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            armed_q <= armed_d;
        end
    end

    // Request history used by the order and yellow-dwell checks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev1_q  <= LAMP_OFF;
            prev2_q  <= LAMP_OFF;
            dwell1_q <= '0;
            dwell2_q <= '0;
        end else begin
            prev1_q  <= prev1_d;
            prev2_q  <= prev2_d;
            dwell1_q <= dwell1_d;
            dwell2_q <= dwell2_d;
        end
    end

    // Fail-safe red blink phase and half-period counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    // Registered lamp drive; reset shows solid red both ways.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamp1_q <= LAMP_RED;
            lamp2_q <= LAMP_RED;
        end else begin
            lamp1_q <= lamp1_d;
            lamp2_q <= lamp2_d;
        end
    end

    assign {lamp_r1, lamp_y1, lamp_g1} = lamp1_q;
    assign {lamp_r2, lamp_y2, lamp_g2} = lamp2_q;
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_safety_monitor.sv
// Directed bench for traffic_light_safety_monitor: table-driven pass-through run plus hand-written fault sequences.
// Outputs are sampled 1 time unit after the rising edge; inputs change only at those sample points.
// Lamp patterns are packed {r1,y1,g1,r2,y2,g2}.
module tb_traffic_light_safety_monitor;

    localparam logic [5:0] RR = 6'b100_100;
    localparam logic [5:0] RG = 6'b100_001;
    localparam logic [5:0] RY = 6'b100_010;
    localparam logic [5:0] GR = 6'b001_100;
    localparam logic [5:0] YR = 6'b010_100;
    localparam logic [5:0] GG = 6'b001_001;
    localparam logic [5:0] BAD1 = 6'b011_001;  // dir1 Y+G, dir2 G: one-hot, conflict and order all violated
    localparam logic [5:0] DARK = 6'b000_000;  // fail-safe lamps during the off half of the blink

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       red1 = 1'b1, yellow1 = 1'b0, green1 = 1'b0;
    logic       red2 = 1'b1, yellow2 = 1'b0, green2 = 1'b0;
    logic       clear_fault = 1'b0;
    logic       lamp_r1, lamp_y1, lamp_g1, lamp_r2, lamp_y2, lamp_g2;
    logic       fault;
    logic [2:0] fault_code;
    logic [5:0] obs_l;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [5:0] in_l;
        logic       clr;
        int         reps;
        logic [5:0] exp_l;
        logic       exp_f;
        logic [2:0] exp_c;
    } vec_t;

    vec_t tbl[6];

    traffic_light_safety_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .red1        (red1),
        .yellow1     (yellow1),
        .green1      (green1),
        .red2        (red2),
        .yellow2     (yellow2),
        .green2      (green2),
        .clear_fault (clear_fault),
        .lamp_r1     (lamp_r1),
        .lamp_y1     (lamp_y1),
        .lamp_g1     (lamp_g1),
        .lamp_r2     (lamp_r2),
        .lamp_y2     (lamp_y2),
        .lamp_g2     (lamp_g2),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    assign obs_l = {lamp_r1, lamp_y1, lamp_g1, lamp_r2, lamp_y2, lamp_g2};

    task automatic check(input string name, input logic [5:0] el, input logic ef, input logic [2:0] ec);
        n_cmp++;
        if ({obs_l, fault, fault_code} !== {el, ef, ec}) begin
            n_bad++;
            $display("FAIL %s @%0t: got lamps=%b fault=%b code=%0d, want lamps=%b fault=%b code=%0d",
                     name, $time, obs_l, fault, fault_code, el, ef, ec);
        end
    endtask

    task automatic drive(input logic [5:0] l, input logic c);
        {red1, yellow1, green1, red2, yellow2, green2} = l;
        clear_fault = c;
    endtask

    task automatic step(input logic [5:0] l, input logic c);
        drive(l, c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] l);
        drive(l, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] prev_l;
        logic       prev_f;
        logic [2:0] prev_c;
        logic [5:0] exp_blink;

        tbl[0] = '{"seq_R1G2", RG, 1'b0, 10, RG, 1'b0, 3'd0};
        tbl[1] = '{"seq_R1Y2", RY, 1'b0,  5, RY, 1'b0, 3'd0};
        tbl[2] = '{"seq_G1R2", GR, 1'b0, 10, GR, 1'b0, 3'd0};
        tbl[3] = '{"seq_Y1R2", YR, 1'b0,  5, YR, 1'b0, 3'd0};
        tbl[4] = '{"seq_R1G2b", RG, 1'b0, 3, RG, 1'b0, 3'd0};
        tbl[5] = '{"conflict", GG, 1'b0,  1, RR, 1'b1, 3'd2};

        // Reset state, then the legal controller cycle with 1-cycle latency checks.
        do_reset(RR);
        check("reset_state", RR, 1'b0, 3'd0);
        prev_l = RR;
        prev_f = 1'b0;
        prev_c = 3'd0;
        for (int v = 0; v < 6; v++) begin
            for (int r = 0; r < tbl[v].reps; r++) begin
                drive(tbl[v].in_l, tbl[v].clr);
                #1;
                check({tbl[v].name, "_hold"}, prev_l, prev_f, prev_c);
                @(posedge clk);
                #1;
                check(tbl[v].name, tbl[v].exp_l, tbl[v].exp_f, tbl[v].exp_c);
                prev_l = tbl[v].exp_l;
                prev_f = tbl[v].exp_f;
                prev_c = tbl[v].exp_c;
            end
        end

        // Fail-safe blink: red on for 25 edges after entry, off 25, on again.
        for (int k = 1; k <= 55; k++) begin
            step(GG, 1'b0);
            exp_blink = (((k / 25) % 2) == 0) ? RR : DARK;
            check("blink", exp_blink, 1'b1, 3'd2);
        end

        // Clear refused while requests are bad, accepted once both directions are red.
        step(GG, 1'b1);
        check("clear_refused", RR, 1'b1, 3'd2);
        step(GG, 1'b0);
        check("clear_not_kept", RR, 1'b1, 3'd2);
        step(RR, 1'b1);
        check("clear_ok", RR, 1'b0, 3'd0);
        step(RG, 1'b0);
        check("resume_RG", RG, 1'b0, 3'd0);

        // Direction 1 G->R while armed.
        for (int r = 0; r < 3; r++) begin
            step(RY, 1'b0);
            check("order_pre_RY", RY, 1'b0, 3'd0);
        end
        step(GR, 1'b0);
        check("order_pre_GR", GR, 1'b0, 3'd0);
        step(RR, 1'b0);
        check("order_G_to_R", RR, 1'b1, 3'd3);

        // Same G->R jump on the first cycle out of reset is not an order fault.
        do_reset(GR);
        check("reset_from_fault", RR, 1'b0, 3'd0);
        step(RR, 1'b0);
        check("unarmed_G_to_R", RR, 1'b0, 3'd0);

        // Yellow held 2 cycles then red.
        for (int r = 0; r < 2; r++) begin
            step(GR, 1'b0);
            check("short_pre_GR", GR, 1'b0, 3'd0);
        end
        for (int r = 0; r < 2; r++) begin
            step(YR, 1'b0);
            check("short_Y", YR, 1'b0, 3'd0);
        end
        step(RR, 1'b0);
        check("short_yellow", RR, 1'b1, 3'd4);

        // Yellow held 251 cycles: fault lands on the 251st.
        do_reset(RR);
        step(RR, 1'b0);
        step(GR, 1'b0);
        step(GR, 1'b0);
        check("long_pre_GR", GR, 1'b0, 3'd0);
        for (int k = 1; k <= 251; k++) begin
            step(YR, 1'b0);
            if (k < 251) begin
                if (k == 1 || k == 249 || k == 250) check("long_Y_ok", YR, 1'b0, 3'd0);
            end else begin
                check("long_yellow", RR, 1'b1, 3'd5);
            end
        end

        // Yellow held exactly 250 cycles then red is legal.
        do_reset(RR);
        step(RR, 1'b0);
        step(GR, 1'b0);
        for (int k = 1; k <= 250; k++) begin
            step(YR, 1'b0);
        end
        check("max_yellow_Y", YR, 1'b0, 3'd0);
        step(RR, 1'b0);
        check("max_yellow_exit", RR, 1'b0, 3'd0);
        step(RR, 1'b0);
        check("max_yellow_after", RR, 1'b0, 3'd0);

        // One-hot violation outranks a simultaneous conflict and order break; code stays frozen.
        do_reset(RR);
        step(RR, 1'b0);
        step(BAD1, 1'b0);
        check("priority_code1", RR, 1'b1, 3'd1);
        for (int k = 1; k <= 30; k++) begin
            step(GG, 1'b0);
        end
        check("frozen_mid_blink", DARK, 1'b1, 3'd1);

        // Asynchronous reset mid-blink restores reset values before any clock edge.
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", RR, 1'b0, 3'd0);

        // clear_fault in NORMAL is inert; a violation alongside it still faults.
        do_reset(RR);
        step(RR, 1'b1);
        check("clear_in_normal", RR, 1'b0, 3'd0);
        step(GG, 1'b1);
        check("viol_with_clear", RR, 1'b1, 3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
